// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output block and its timebase.
package pwm_pkg;

    localparam int PWM_RES          = 8;
    localparam int NUM_CH           = 16;
    localparam int PWM_PERIOD_STEPS = 256;

    typedef logic [PWM_RES-1:0] duty_t;

    localparam duty_t DUTY_FULL  = 8'hFF;
    localparam duty_t COUNT_LAST = duty_t'(PWM_PERIOD_STEPS - 1);

    // Prescaler needs at least one bit even when it never leaves zero.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM counter; emits the step tick and the end-of-period wrap.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        tick,
    output logic [7:0]  pwm_count,
    output logic        wrap
);

    localparam int                PW         = presc_width(CLK_DIV);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler;

    assign tick = (prescaler == PRESC_LAST);
    assign wrap = tick && (pwm_count == COUNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            pwm_count <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                pwm_count <= pwm_count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage driven by the SPI configuration registers.
// Define PWM_SYNC_UPDATE_EN to latch duty changes only at period boundaries.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    logic              tick_unused;
    duty_t             pwm_count;
    logic              wrap;
    duty_t             duty_active;
    logic              pwm_raw;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick_unused),
        .pwm_count (pwm_count),
        .wrap      (wrap)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
        end else begin
`ifdef PWM_SYNC_UPDATE_EN
            if (wrap)
                duty_active <= pwm_duty_cycle;
`else
            duty_active <= pwm_duty_cycle;
`endif
        end
    end

    // Full-scale duty is forced high so 0xFF never drops for the last step.
    always_comb begin
        pwm_raw = 1'b0;
        if (duty_active == DUTY_FULL)
            pwm_raw = 1'b1;
        else
            pwm_raw = (pwm_count < duty_active);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= en_out & (~en_pwm | {NUM_CH{pwm_raw}});
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral at CLK_DIV=4.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 4;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_reg_out_7_0 = '0;
    logic [7:0]  en_reg_out_15_8 = '0;
    logic [7:0]  en_reg_pwm_7_0 = '0;
    logic [7:0]  en_reg_pwm_15_8 = '0;
    logic [7:0]  pwm_duty_cycle = '0;
    logic [15:0] out;
    logic        period_start;

    int tests = 0;
    int fails = 0;

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        pwm_duty_cycle  = d;
    endtask

    task automatic wait_ps(input string tag);
        int  i;
        bit  found;
        i     = 0;
        found = 1'b0;
        while (!found && i < PERIOD + 64) begin
            @(negedge clk);
            i++;
            found = period_start;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Let a new duty reach the output in either update mode.
    task automatic settle(input string tag);
        wait_ps(tag);
        repeat (2) @(negedge clk);
    endtask

    task automatic measure(input string tag, input logic [15:0] mask,
                           output int hi0, output int hi4, output int bad, output int gap);
        wait_ps(tag);
        hi0 = 0; hi4 = 0; bad = 0; gap = 0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            hi0 += int'(out[0]);
            hi4 += int'(out[4]);
            if (out !== 16'h0000 && out !== mask) bad++;
            if (period_start && gap == 0) gap = k;
        end
    endtask

    initial begin
        int hi0, hi4, bad, gap, cnt, first_ps;
        logic [15:0] s514;

        // Reset behaviour
        set_cfg(16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(out), 32'h0);
        check("rst_ps", 32'(period_start), 32'h0);
        set_cfg(16'h00FF, 16'h0000, 8'h80);
        @(negedge clk);
        check("rst_out_held", 32'(out), 32'h0);
        set_cfg(16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_idle", 32'(out), 32'h0);
        set_cfg(16'h00FF, 16'h0000, 8'h80);
        @(negedge clk);
        check("t1_static_on", 32'(out), 32'h00FF);

        // 50% duty on all channels
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        settle("t2_settle");
        measure("t2_ps", 16'hFFFF, hi0, hi4, bad, gap);
        check("t2_hi0", hi0, 512);
        check("t2_hi4", hi4, 512);
        check("t2_bad", bad, 0);
        check("t2_gap", gap, PERIOD);

        // Duty extremes and minimum pulse
        pwm_duty_cycle = 8'h00;
        settle("t3a_settle");
        cnt = 0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            @(negedge clk);
            if (out !== 16'h0000) cnt++;
        end
        check("t3_duty00_high", cnt, 0);

        pwm_duty_cycle = 8'hFF;
        settle("t3b_settle");
        cnt = 0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            @(negedge clk);
            if (out !== 16'hFFFF) cnt++;
        end
        check("t3_dutyFF_low", cnt, 0);

        pwm_duty_cycle = 8'h01;
        settle("t3c_settle");
        measure("t3c_ps", 16'hFFFF, hi0, hi4, bad, gap);
        check("t3_duty01_hi", hi0, CLK_DIV);
        check("t3_duty01_bad", bad, 0);

        // Output enable overrides PWM enable
        set_cfg(16'h0F0F, 16'hFFFF, 8'h40);
        settle("t4_settle");
        measure("t4_ps", 16'h0F0F, hi0, hi4, bad, gap);
        check("t4_hi0", hi0, 256);
        check("t4_hi4", hi4, 0);
        check("t4_bad", bad, 0);

        // Mid-period duty change at count 0x80
        set_cfg(16'hFFFF, 16'hFFFF, 8'h40);
        settle("t5_settle");
        wait_ps("t5_ps");
        hi0 = 0; gap = 0; s514 = '0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            hi0 += int'(out[0]);
            if (k == 514) s514 = out;
            if (period_start && gap == 0) gap = k;
            if (k == 512) pwm_duty_cycle = 8'hC0;
        end
`ifdef PWM_SYNC_UPDATE_EN
        check("t5_cur_hi", hi0, 256);
        check("t5_s514", 32'(s514), 32'h0000);
`else
        check("t5_cur_hi", hi0, 511);
        check("t5_s514", 32'(s514), 32'hFFFF);
`endif
        check("t5_gap", gap, PERIOD);
        hi0 = 0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            hi0 += int'(out[0]);
        end
        check("t5_next_hi", hi0, 768);

        // Asynchronous reset at count 0x9A
        wait_ps("t6_ps");
        repeat (616) @(negedge clk);
        check("t6_pre_rst", 32'(out), 32'hFFFF);
        rst_n = 1'b0;
        #1;
        check("t6_async_out", 32'(out), 32'h0);
        check("t6_async_ps", 32'(period_start), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        first_ps = 0;
        for (int k = 1; k <= 2 * PERIOD && first_ps == 0; k++) begin
            @(negedge clk);
            if (period_start) first_ps = k;
        end
        check("t6_first_ps", first_ps, PERIOD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
